// File: rtl/simd_wave_sequencer.sv
// Per-SIMD-unit wave sequencer: steps each instruction over every lane group of a wave.
// Optional WAIT timeout abort is enabled with `define SIMD_WAVE_TIMEOUT_EN.
module simd_wave_sequencer #(
  parameter int unsigned WAVE_SIZE   = 32,
  parameter int unsigned LANE_WIDTH  = 16,
  parameter int unsigned MEM_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        launch,
  input  logic [31:0] launch_wave_id,
  output logic [31:0] wave_id,
  output logic        busy,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        issue_is_mem,
  input  logic        issue_reg_write,
  input  logic        issue_halt,
  output logic        mem_req,
  input  logic        mem_done,
  output logic [2:0]  simd_state,
  output logic [$clog2((WAVE_SIZE+LANE_WIDTH-1)/LANE_WIDTH):0] curr_wave_cycle,
  output logic        rf_enable,
  output logic        rf_reg_write,
  output logic        instr_done,
  output logic        wave_done,
  output logic        mem_timeout
);

  localparam int unsigned WAVE_CYCLES = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH;
  localparam int unsigned CW          = $clog2(WAVE_CYCLES) + 1;
  localparam int unsigned TW          = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CYC  = CW'(WAVE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_REQUEST = 3'd2,
    S_EXECUTE = 3'd3,
    S_WAIT    = 3'd4,
    S_UPDATE  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cyc_nxt;
  logic          accept;
  logic          lat_mem;
  logic          lat_rw;
  logic          tmo_hit;

  assign simd_state = state;

`ifdef SIMD_WAVE_TIMEOUT_EN
  logic [TW-1:0] tcnt;

  // Expiry only when mem_done is absent this cycle; a late mem_done still wins.
  assign tmo_hit = (state == S_WAIT) && !mem_done && (tcnt == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (state != S_WAIT)
        tcnt <= '0;
      else
        tcnt <= TW'(tcnt + 1'b1);
      if (tmo_hit)
        mem_timeout <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo  = ^TW'(MEM_TIMEOUT);
  assign tmo_hit     = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  // Next-state and next lane-group selection.
  always_comb begin
    nxt     = state;
    cyc_nxt = curr_wave_cycle;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch)
          nxt = S_FETCH;
      end
      S_FETCH: begin
        if (issue_valid) begin
          accept = 1'b1;
          if (issue_halt) begin
            nxt = S_DONE;
          end else begin
            nxt     = S_REQUEST;
            cyc_nxt = '0;
          end
        end
      end
      S_REQUEST: nxt = S_EXECUTE;
      S_EXECUTE: nxt = lat_mem ? S_WAIT : S_UPDATE;
      S_WAIT: begin
        if (mem_done)
          nxt = S_UPDATE;
        else if (tmo_hit)
          nxt = S_DONE;
      end
      S_UPDATE: begin
        if (curr_wave_cycle == LAST_CYC) begin
          nxt     = S_FETCH;
          cyc_nxt = '0;
        end else begin
          nxt     = S_REQUEST;
          cyc_nxt = CW'(curr_wave_cycle + 1'b1);
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // State, latches and outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      curr_wave_cycle <= '0;
      wave_id         <= '0;
      lat_mem         <= 1'b0;
      lat_rw          <= 1'b0;
      busy            <= 1'b0;
      rf_enable       <= 1'b0;
      issue_ready     <= 1'b0;
      mem_req         <= 1'b0;
      rf_reg_write    <= 1'b0;
      instr_done      <= 1'b0;
      wave_done       <= 1'b0;
    end else begin
      state           <= nxt;
      curr_wave_cycle <= cyc_nxt;
      if (state == S_IDLE && launch)
        wave_id <= launch_wave_id;
      if (accept) begin
        lat_mem <= issue_is_mem;
        lat_rw  <= issue_reg_write;
      end
      busy         <= (nxt != S_IDLE);
      rf_enable    <= (nxt != S_IDLE);
      issue_ready  <= (nxt == S_FETCH);
      mem_req      <= (nxt == S_WAIT);
      rf_reg_write <= (nxt == S_UPDATE) && lat_rw;
      instr_done   <= (nxt == S_UPDATE) && (cyc_nxt == LAST_CYC);
      wave_done    <= (nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_simd_wave_sequencer.sv
// Randomized bench for simd_wave_sequencer against a per-cycle expected trace model.
module tb_simd_wave_sequencer;

  localparam int unsigned WC = (32 + 16 - 1) / 16;
  localparam int unsigned CW = $clog2(WC) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          launch;
  logic [31:0]   launch_wave_id;
  logic [31:0]   wave_id;
  logic          busy;
  logic          issue_valid;
  logic          issue_ready;
  logic          issue_is_mem;
  logic          issue_reg_write;
  logic          issue_halt;
  logic          mem_req;
  logic          mem_done;
  logic [2:0]    simd_state;
  logic [CW-1:0] curr_wave_cycle;
  logic          rf_enable;
  logic          rf_reg_write;
  logic          instr_done;
  logic          wave_done;
  logic          mem_timeout;

  always #5 clk = ~clk;

  simd_wave_sequencer #(
    .WAVE_SIZE(32), .LANE_WIDTH(16), .MEM_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .launch(launch), .launch_wave_id(launch_wave_id),
    .wave_id(wave_id), .busy(busy), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_is_mem(issue_is_mem), .issue_reg_write(issue_reg_write), .issue_halt(issue_halt),
    .mem_req(mem_req), .mem_done(mem_done), .simd_state(simd_state),
    .curr_wave_cycle(curr_wave_cycle), .rf_enable(rf_enable), .rf_reg_write(rf_reg_write),
    .instr_done(instr_done), .wave_done(wave_done), .mem_timeout(mem_timeout)
  );

  // One expected cycle: observed state/outputs plus what the bench drives during it.
  typedef struct {
    int st;
    int cyc;
    bit rfw;
    bit idone;
    bit mto;
    bit v;
    bit md;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] cur_id = '0;
  int          cyc_now = 0;
  bit          exp_mto = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int st, input int cyc, input bit rfw, input bit idone,
                              input bit v, input bit md);
    exp_t e;
    e.st = st; e.cyc = cyc; e.rfw = rfw; e.idone = idone;
    e.mto = exp_mto; e.v = v; e.md = md;
    return e;
  endfunction

  task automatic check_outs(input exp_t e);
    chk("simd_state", 32'(simd_state), 32'(e.st));
    chk("curr_wave_cycle", 32'(curr_wave_cycle), 32'(e.cyc));
    chk("busy", 32'(busy), 32'(e.st != 0));
    chk("rf_enable", 32'(rf_enable), 32'(e.st != 0));
    chk("issue_ready", 32'(issue_ready), 32'(e.st == 1));
    chk("mem_req", 32'(mem_req), 32'(e.st == 4));
    chk("rf_reg_write", 32'(rf_reg_write), 32'(e.rfw));
    chk("instr_done", 32'(instr_done), 32'(e.idone));
    chk("wave_done", 32'(wave_done), 32'(e.st == 6));
    chk("mem_timeout", 32'(mem_timeout), 32'(e.mto));
    chk("wave_id", wave_id, (e.st == 0 && cur_id == 0) ? 32'd0 : cur_id);
  endtask

  // Replay the expected trace; launch/valid/mem_done noise goes only where it must be ignored.
  task automatic run_q();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check_outs(e);
      mem_done       = e.md | ((e.st != 4) && ($urandom_range(0, 1) == 1));
      issue_valid    = e.v | ((e.st != 1) && ($urandom_range(0, 1) == 1));
      launch         = (e.st != 0) && ($urandom_range(0, 1) == 1);
      launch_wave_id = $urandom;
      tick();
    end
    mem_done    = 1'b0;
    issue_valid = 1'b0;
    launch      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cur_id  = '0;
    cyc_now = 0;
    exp_mto = 1'b0;
  endtask

  task automatic launch_wave(input logic [31:0] id);
    chk("pre_launch_state", 32'(simd_state), 32'd0);
    launch         = 1'b1;
    launch_wave_id = id;
    tick();
    launch = 1'b0;
    cur_id = id;
  endtask

  // Expected trace from the instruction rules: each lane group is REQ, EXE, [WAIT x k], UPD.
  task automatic do_instr(input bit mem, input bit rw, input bit halt, input int idle,
                          input int kfix);
    int k;
    issue_is_mem    = mem;
    issue_reg_write = rw;
    issue_halt      = halt;
    for (int i = 0; i < idle; i++) q.push_back(mk(1, cyc_now, 0, 0, 0, 0));
    q.push_back(mk(1, cyc_now, 0, 0, 1, 0));
    if (halt) begin
      q.push_back(mk(6, cyc_now, 0, 0, 0, 0));
      q.push_back(mk(0, cyc_now, 0, 0, 0, 0));
    end else begin
      for (int c = 0; c < int'(WC); c++) begin
        q.push_back(mk(2, c, 0, 0, 0, 0));
        q.push_back(mk(3, c, 0, 0, 0, 0));
        if (mem) begin
          k = (kfix > 0) ? kfix : int'($urandom_range(1, 6));
          for (int w = 0; w < k; w++) q.push_back(mk(4, c, 0, 0, 0, w == k - 1));
        end
        q.push_back(mk(5, c, rw, c == int'(WC) - 1, 0, 0));
      end
      cyc_now = 0;
      q.push_back(mk(1, 0, 0, 0, 0, 0));
    end
    run_q();
  endtask

  initial begin
    launch = 0; launch_wave_id = 0; issue_valid = 0; issue_is_mem = 0;
    issue_reg_write = 0; issue_halt = 0; mem_done = 0;
    do_reset();
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    run_q();

    launch_wave(32'd3);
    do_instr(0, 1, 0, 0, 0);
    do_instr(1, $urandom_range(0, 1) == 1, 0, 0, 4);
    do_instr(0, 0, 0, 5, 0);
    for (int n = 0; n < 6; n++)
      do_instr($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0,
               int'($urandom_range(0, 2)), 0);
    do_instr(0, 1, 1, 1, 0);

    // Asynchronous reset in the middle of EXECUTE.
    launch_wave($urandom);
    issue_is_mem = 1; issue_reg_write = 1; issue_halt = 0;
    q.push_back(mk(1, 0, 0, 0, 1, 0));
    q.push_back(mk(2, 0, 0, 0, 0, 0));
    run_q();
    chk("pre_rst_state", 32'(simd_state), 32'd3);
    #2 rst = 1'b1;
    #1;
    cur_id = '0; cyc_now = 0; exp_mto = 1'b0;
    check_outs(mk(0, 0, 0, 0, 0, 0));
    tick();
    rst = 1'b0;
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    run_q();

    launch_wave($urandom);
    do_instr(1, 1, 0, 0, 0);
    do_instr(0, 1, 1, 0, 0);

`ifdef SIMD_WAVE_TIMEOUT_EN
    launch_wave(32'h55);
    issue_is_mem = 1; issue_reg_write = 1; issue_halt = 0;
    q.push_back(mk(1, 0, 0, 0, 1, 0));
    q.push_back(mk(2, 0, 0, 0, 0, 0));
    q.push_back(mk(3, 0, 0, 0, 0, 0));
    for (int w = 0; w < 8; w++) q.push_back(mk(4, 0, 0, 0, 0, 0));
    exp_mto = 1'b1;
    q.push_back(mk(6, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    run_q();
    launch_wave(32'h66);
    q.push_back(mk(1, 0, 0, 0, 0, 0));
    run_q();
    do_reset();
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    run_q();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
